// File: rtl/hub75_pkg.sv
// Shared constants and scan-state encoding for the HUB75 scan controller and
// the fetch/shift stage it drives.
package hub75_pkg;

  localparam int DEF_ROWS         = 32;
  localparam int DEF_BITS         = 8;
  localparam int DEF_BASE_CYCLES  = 16;
  localparam int DEF_BLANK_CYCLES = 2;
  localparam int DEF_LAT_GUARD    = 4;
  localparam int DEF_TIMER_W      = 16;

  localparam int BIT_W   = 3;
  localparam int ROW_W   = 6;
  localparam int ADDR_W  = 5;
  localparam int PHASE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KICK,
    ST_WAIT_ACK,
    ST_SHIFTING,
    ST_GUARD,
    ST_BLANK,
    ST_LATCH,
    ST_HOLD
  } scan_state_e;

  // States in which the panel is forced dark regardless of the display timer.
  function automatic logic is_blank_state(input scan_state_e s);
    return s inside {ST_BLANK, ST_LATCH, ST_HOLD};
  endfunction

endpackage

// File: rtl/bcm_display_timer.sv
// Binary-code-modulation on-time timer: load BASE_CYCLES<<shift, then count
// down to zero; the panel is lit exactly while the count is nonzero.
module bcm_display_timer
  import hub75_pkg::*;
#(
  parameter int BASE_CYCLES = DEF_BASE_CYCLES,
  parameter int TIMER_W     = DEF_TIMER_W,
  parameter int SHIFT_W     = BIT_W
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               load,
  input  logic [SHIFT_W-1:0] shift,
  output logic               running,
  output logic               oe_n_raw
);

  logic [TIMER_W-1:0] count;

  assign running  = (count != '0);
  assign oe_n_raw = ~running;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= TIMER_W'(BASE_CYCLES) << shift;
    end else if (running) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/wrap_counter.sv
// Modulo counter: counts 0..MAX on inc, wraps to 0, synchronous clear.
module wrap_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         at_max
);

  assign at_max = (q == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row/bit-plane sequencer: kicks the fetch/shift stage, latches each
// shifted plane and lights it for a binary-weighted time while the next plane shifts.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int BITS         = DEF_BITS,
  parameter int BASE_CYCLES  = DEF_BASE_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int LAT_GUARD    = DEF_LAT_GUARD,
  parameter int TIMER_W      = DEF_TIMER_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              enable,
  output logic              fs_start,
  input  logic              fs_busy,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic [ROW_W-1:0]  row_cnt,
  output logic [ADDR_W-1:0] addr,
  output logic              lat,
  output logic              oe_n,
  output logic              frame_done
);

  scan_state_e        state_q, state_d;
  logic [PHASE_W-1:0] ph_cnt;
  logic [BIT_W-1:0]   disp_bit;
  logic               hold_exit;
  logic               guard_ok, blank_done;
  logic               bit_at_max, row_at_max;
  logic               bit_inc, row_inc, cnt_clr;
  logic               running, oe_n_raw;

  assign guard_ok   = (ph_cnt >= PHASE_W'(LAT_GUARD - 1));
  assign blank_done = (ph_cnt == PHASE_W'(BLANK_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    hold_exit = 1'b0;
    fs_start  = 1'b0;
    lat       = 1'b0;
    case (state_q)
      ST_IDLE:     if (enable) state_d = ST_KICK;
      ST_KICK: begin
        fs_start = 1'b1;
        state_d  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: if (fs_busy) state_d = ST_SHIFTING;
      ST_SHIFTING: if (!fs_busy) state_d = ST_GUARD;
      // Next latch is held off until the previously latched plane has gone dark.
      ST_GUARD:    if (guard_ok && !running) state_d = ST_BLANK;
      ST_BLANK:    if (blank_done) state_d = ST_LATCH;
      ST_LATCH: begin
        lat     = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (blank_done) begin
          hold_exit = 1'b1;
          state_d   = enable ? ST_KICK : ST_IDLE;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // ph_cnt restarts on every state change and saturates so long GUARD stalls stay valid.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        ph_cnt <= '0;
      end else if (ph_cnt != '1) begin
        ph_cnt <= ph_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      addr       <= '0;
      disp_bit   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= hold_exit && bit_at_max && row_at_max;
      if (state_q == ST_LATCH) begin
        addr     <= row_cnt[ADDR_W-1:0];
        disp_bit <= bit_cnt;
      end
    end
  end

  // Stopping returns both counters to 0 so the next run starts with a fetch.
  assign bit_inc = hold_exit && enable;
  assign row_inc = bit_inc && bit_at_max;
  assign cnt_clr = hold_exit && !enable;

  wrap_counter #(
    .W   (BIT_W),
    .MAX (BITS - 1)
  ) u_bit_cnt (
    .clk    (sys_clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (bit_inc),
    .q      (bit_cnt),
    .at_max (bit_at_max)
  );

  wrap_counter #(
    .W   (ROW_W),
    .MAX (ROWS - 1)
  ) u_row_cnt (
    .clk    (sys_clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (row_inc),
    .q      (row_cnt),
    .at_max (row_at_max)
  );

  bcm_display_timer #(
    .BASE_CYCLES (BASE_CYCLES),
    .TIMER_W     (TIMER_W),
    .SHIFT_W     (BIT_W)
  ) u_timer (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .load     (hold_exit),
    .shift    (disp_bit),
    .running  (running),
    .oe_n_raw (oe_n_raw)
  );

  assign oe_n = oe_n_raw || is_blank_state(state_q);

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: a 32x8 instance for timing/BCM/enable
// behaviour and a 2x2 instance for frame wrap, each with a simple shifter model.
module tb_hub75_scan_ctrl;

  localparam int BASE  = 4;
  localparam int BLANK = 2;
  localparam int GUARD = 4;

  logic sys_clk = 1'b0;
  logic rst;

  logic       en_a, start_a, lat_a, oen_a, fd_a;
  logic       busy_a = 1'b0;
  logic [2:0] bit_a;
  logic [5:0] row_a;
  logic [4:0] addr_a;

  logic       en_b, start_b, lat_b, oen_b, fd_b;
  logic       busy_b = 1'b0;
  logic [2:0] bit_b;
  logic [5:0] row_b;
  logic [4:0] addr_b;

  int n_checks = 0;
  int n_errors = 0;

  hub75_scan_ctrl #(
    .ROWS(32), .BITS(8), .BASE_CYCLES(BASE), .BLANK_CYCLES(BLANK),
    .LAT_GUARD(GUARD), .TIMER_W(16)
  ) dut_a (
    .sys_clk(sys_clk), .rst(rst), .enable(en_a), .fs_start(start_a),
    .fs_busy(busy_a), .bit_cnt(bit_a), .row_cnt(row_a), .addr(addr_a),
    .lat(lat_a), .oe_n(oen_a), .frame_done(fd_a)
  );

  hub75_scan_ctrl #(
    .ROWS(2), .BITS(2), .BASE_CYCLES(BASE), .BLANK_CYCLES(BLANK),
    .LAT_GUARD(GUARD), .TIMER_W(16)
  ) dut_b (
    .sys_clk(sys_clk), .rst(rst), .enable(en_b), .fs_start(start_b),
    .fs_busy(busy_b), .bit_cnt(bit_b), .row_cnt(row_b), .addr(addr_b),
    .lat(lat_b), .oe_n(oen_b), .frame_done(fd_b)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  // Instance A: monitor + shifter model
  int   busy_len_a = 10;
  int   left_a, starts_a, fall_cyc_a, cyc_a, lo_run_a, hi_run_a;
  logic prev_busy_a = 1'b0;
  logic [2:0] sb_a = '0;
  logic [5:0] sr_a = '0;
  logic [4:0] prev_addr_a = '0;
  int   widths_a[$];
  int   lats_a[$];
  bit   delay_chk_a = 0;
  bit   gap_chk_a = 0;

  always begin
    @(posedge sys_clk);
    #1;
    cyc_a++;
    if (!rst) begin
      if (lat_a) begin
        check("lat_oe_a", int'(oen_a), 1);
        lats_a.push_back(int'(row_a) * 16 + int'(bit_a));
        if (delay_chk_a) check("lat_delay", cyc_a - fall_cyc_a, GUARD + BLANK);
        if (gap_chk_a && bit_a >= 3'd3) check("stall_gap", hi_run_a, BLANK + 1);
      end
      if (addr_a != prev_addr_a) check("addr_change_oe", int'(oen_a), 1);
      if (busy_a) begin
        check("bit_stable", int'(bit_a), int'(sb_a));
        check("row_stable", int'(row_a), int'(sr_a));
      end
      if (prev_busy_a && !busy_a) fall_cyc_a = cyc_a;
    end
    if (!oen_a) begin
      lo_run_a++;
      hi_run_a = 0;
    end else begin
      if (lo_run_a > 0) widths_a.push_back(lo_run_a);
      lo_run_a = 0;
      hi_run_a++;
    end
    prev_addr_a = addr_a;
    prev_busy_a = busy_a;
    if (start_a) begin
      starts_a++;
      sb_a   = bit_a;
      sr_a   = row_a;
      busy_a = 1'b1;
      left_a = busy_len_a;
    end else if (busy_a) begin
      left_a--;
      if (left_a == 0) busy_a = 1'b0;
    end
  end

  // Instance B: monitor + shifter model
  int   busy_len_b = 6;
  int   left_b, fd_cnt_b;
  logic [5:0] prev_row_b = '0;
  int   lats_b[$];

  always begin
    @(posedge sys_clk);
    #1;
    if (!rst) begin
      if (lat_b) begin
        check("lat_oe_b", int'(oen_b), 1);
        lats_b.push_back(int'(row_b) * 16 + int'(bit_b));
      end
      if (fd_b) begin
        fd_cnt_b++;
        check("fd_row", int'(row_b), 0);
        check("fd_bit", int'(bit_b), 0);
        check("fd_prev_row", int'(prev_row_b), 1);
      end
    end
    prev_row_b = row_b;
    if (start_b) begin
      busy_b = 1'b1;
      left_b = busy_len_b;
    end else if (busy_b) begin
      left_b--;
      if (left_b == 0) busy_b = 1'b0;
    end
  end

  initial begin
    int n_st;
    rst  = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    repeat (3) begin
      @(posedge sys_clk);
      #2;
      check("rst_oe_n", int'(oen_a), 1);
      check("rst_lat", int'(lat_a), 0);
      check("rst_start", int'(start_a), 0);
      check("rst_bit", int'(bit_a), 0);
      check("rst_row", int'(row_a), 0);
    end
    en_a = 1'b0;
    en_b = 1'b0;
    rst  = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;

    // Single plane: one-cycle enable pulse
    lats_a.delete();
    widths_a.delete();
    starts_a    = 0;
    delay_chk_a = 1;
    en_a = 1'b1;
    @(posedge sys_clk);
    #2;
    en_a = 1'b0;
    for (int i = 0; i < 200 && widths_a.size() == 0; i++) begin
      @(posedge sys_clk);
      #2;
    end
    check("single_width_seen", widths_a.size(), 1);
    check("single_width", qget(widths_a, 0), BASE);
    check("single_lat_cnt", lats_a.size(), 1);
    check("single_lat_rb", qget(lats_a, 0), 0);
    check("single_addr", int'(addr_a), 0);
    repeat (20) @(posedge sys_clk);
    #2;
    check("single_starts", starts_a, 1);
    check("single_idle_oe", int'(oen_a), 1);
    check("single_idle_bit", int'(bit_a), 0);
    check("single_idle_row", int'(row_a), 0);
    delay_chk_a = 0;

    // BCM weights across row 0, with overlap stalls on long planes
    lats_a.delete();
    widths_a.delete();
    gap_chk_a = 1;
    en_a = 1'b1;
    for (int i = 0; i < 6000 && widths_a.size() < 8; i++) begin
      @(posedge sys_clk);
      #2;
    end
    check("bcm_width_cnt", widths_a.size(), 8);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("bcm_w%0d", b), qget(widths_a, b), BASE << b);
      check($sformatf("bcm_lat%0d", b), qget(lats_a, b), b);
    end
    gap_chk_a = 0;

    // Drop enable while row 1 plane 1 is shifting
    for (int i = 0; i < 200 && !busy_a; i++) begin
      @(posedge sys_clk);
      #2;
    end
    check("drop_busy_seen", int'(busy_a), 1);
    lats_a.delete();
    en_a = 1'b0;
    n_st = starts_a;
    for (int i = 0; i < 200 && lats_a.size() == 0; i++) begin
      @(posedge sys_clk);
      #2;
    end
    check("drop_lat_rb", qget(lats_a, 0), 16 + 1);
    widths_a.delete();
    for (int i = 0; i < 200 && widths_a.size() == 0; i++) begin
      @(posedge sys_clk);
      #2;
    end
    check("drop_width", qget(widths_a, 0), BASE << 1);
    repeat (20) @(posedge sys_clk);
    #2;
    check("drop_lat_cnt", lats_a.size(), 1);
    check("drop_no_restart", starts_a, n_st);
    check("drop_bit", int'(bit_a), 0);
    check("drop_row", int'(row_a), 0);
    check("drop_oe", int'(oen_a), 1);

    // Re-enable: first start fetches row 0 plane 0
    en_a = 1'b1;
    for (int i = 0; i < 50 && !start_a; i++) begin
      @(posedge sys_clk);
      #2;
    end
    check("reen_start", int'(start_a), 1);
    check("reen_bit", int'(bit_a), 0);
    check("reen_row", int'(row_a), 0);
    en_a = 1'b0;
    repeat (60) @(posedge sys_clk);
    #2;

    // Frame wrap on the 2-row x 2-plane instance
    en_b = 1'b1;
    for (int i = 0; i < 2000 && lats_b.size() < 5; i++) begin
      @(posedge sys_clk);
      #2;
    end
    for (int i = 0; i < 5; i++)
      check($sformatf("wrap_lat%0d", i), qget(lats_b, i), ((i / 2) % 2) * 16 + (i % 2));
    check("wrap_fd_cnt1", fd_cnt_b, 1);
    for (int i = 0; i < 2000 && lats_b.size() < 9; i++) begin
      @(posedge sys_clk);
      #2;
    end
    for (int i = 5; i < 9; i++)
      check($sformatf("wrap_lat%0d", i), qget(lats_b, i), ((i / 2) % 2) * 16 + (i % 2));
    check("wrap_fd_cnt2", fd_cnt_b, 2);
    en_b = 1'b0;
    repeat (100) @(posedge sys_clk);
    #2;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
